// File: rtl/stream_accumulator.sv
// stream_accumulator
//   Sums a frame of unsigned products and emits one wide sum per frame.
//   A frame ends after LEN accepted beats or on an accepted beat carrying
//   i_last, whichever comes first. Ready/valid on both sides. The output
//   side can apply full backpressure. The input stalls while a sum is
//   waiting to be taken.
//
// Optional feature: define STREAM_ACCUMULATOR_SAT_EN to make the accumulator
//   saturate at 2^ACC_W-1 instead of wrapping. This also adds the o_sat port.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   i_valid    product beat valid
//   i_ready    block can accept a product beat
//   i_payload  unsigned product (IN_W)
//   i_last     final beat of frame, sampled only on accept
//   o_valid    frame sum valid
//   o_ready    downstream accepts the sum
//   o_payload  frame sum (ACC_W)
//   o_count    number of products summed into o_payload (CNT_W)
//   o_sat      (SAT_EN only) some addition in the frame saturated
module stream_accumulator #(
   parameter int IN_W  = 32,
   parameter int ACC_W = 40,
   parameter int LEN   = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic [IN_W-1:0]  i_payload,
   input  logic             i_last,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [ACC_W-1:0] o_payload,
   output logic [CNT_W-1:0] o_count
`ifdef STREAM_ACCUMULATOR_SAT_EN
  ,output logic             o_sat
`endif
);

   typedef enum logic {S_ACCUM, S_OUTPUT} state_t;

   state_t           r_state;
   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_valid;
   logic [ACC_W-1:0] r_payload;
   logic [CNT_W-1:0] r_count;

   logic             w_accept;
   logic             w_final;
   logic [ACC_W-1:0] w_sum;

   // i_ready depends only on state and reset, never on o_ready.
   assign i_ready  = reset & (r_state == S_ACCUM);
   assign w_accept = i_valid & i_ready;
   // i_last on the LEN-th beat still ends the frame only once.
   assign w_final  = (r_cnt == CNT_W'(LEN - 1)) | i_last;

`ifdef STREAM_ACCUMULATOR_SAT_EN
   logic             r_sat_acc;   // sticky saturation flag for the frame in progress
   logic             r_sat;
   logic [ACC_W:0]   w_sum_ext;
   logic             w_sat_now;

   assign w_sum_ext = {1'b0, r_acc} + {{(ACC_W + 1 - IN_W){1'b0}}, i_payload};
   assign w_sat_now = w_sum_ext[ACC_W];
   assign w_sum     = w_sat_now ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
   assign o_sat     = r_sat;
`else
   assign w_sum     = r_acc + ACC_W'(i_payload);
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_ACCUM;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_valid   <= 1'b0;
         r_payload <= '0;
         r_count   <= '0;
`ifdef STREAM_ACCUMULATOR_SAT_EN
         r_sat_acc <= 1'b0;
         r_sat     <= 1'b0;
`endif
      end else if (r_state == S_ACCUM) begin
         if (w_accept) begin
            if (w_final) begin
               r_payload <= w_sum;
               r_count   <= r_cnt + 1'b1;
               r_acc     <= '0;
               r_cnt     <= '0;
               r_valid   <= 1'b1;
               r_state   <= S_OUTPUT;
`ifdef STREAM_ACCUMULATOR_SAT_EN
               r_sat     <= r_sat_acc | w_sat_now;
               r_sat_acc <= 1'b0;
`endif
            end else begin
               r_acc     <= w_sum;
               r_cnt     <= r_cnt + 1'b1;
`ifdef STREAM_ACCUMULATOR_SAT_EN
               r_sat_acc <= r_sat_acc | w_sat_now;
`endif
            end
         end
      end else begin
         // Sum, count and flag stay frozen until the consumer takes them.
         if (o_ready) begin
            r_valid <= 1'b0;
            r_state <= S_ACCUM;
         end
      end
   end

   assign o_valid   = r_valid;
   assign o_payload = r_payload;
   assign o_count   = r_count;

endmodule

// File: tb/tb_stream_accumulator.sv
// Scoreboard bench for stream_accumulator.
// Instance 1 uses the default parameters (ACC_W=40).
// Instance 2 uses ACC_W=33 to exercise wrap or saturation.
module tb_stream_accumulator;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        v1 = 1'b0, v2 = 1'b0;
   logic        rdy1, rdy2;
   logic [31:0] i_payload = '0;
   logic        i_last = 1'b0;
   logic        o_ready = 1'b1;
   logic        ov1, ov2;
   logic [39:0] pay1;
   logic [32:0] pay2;
   logic [7:0]  cnt1, cnt2;
`ifdef STREAM_ACCUMULATOR_SAT_EN
   logic        sat1, sat2;
`endif

   int nvec = 0;
   int nfail = 0;

   typedef struct {
      logic [63:0] pay;
      logic [7:0]  cnt;
      logic        sat;
   } exp_t;
   exp_t q1[$];
   exp_t q2[$];

   always #5 clk = ~clk;

   stream_accumulator #(.IN_W(32), .ACC_W(40), .LEN(4), .CNT_W(8)) dut1 (
      .clk(clk), .reset(reset), .i_valid(v1), .i_ready(rdy1),
      .i_payload(i_payload), .i_last(i_last), .o_valid(ov1), .o_ready(o_ready),
      .o_payload(pay1), .o_count(cnt1)
`ifdef STREAM_ACCUMULATOR_SAT_EN
     ,.o_sat(sat1)
`endif
   );

   stream_accumulator #(.IN_W(32), .ACC_W(33), .LEN(4), .CNT_W(8)) dut2 (
      .clk(clk), .reset(reset), .i_valid(v2), .i_ready(rdy2),
      .i_payload(i_payload), .i_last(i_last), .o_valid(ov2), .o_ready(o_ready),
      .o_payload(pay2), .o_count(cnt2)
`ifdef STREAM_ACCUMULATOR_SAT_EN
     ,.o_sat(sat2)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic push1(input logic [63:0] p, input logic [7:0] c, input logic s);
      exp_t e;
      e.pay = p; e.cnt = c; e.sat = s;
      q1.push_back(e);
   endtask

   task automatic push2(input logic [63:0] p, input logic [7:0] c, input logic s);
      exp_t e;
      e.pay = p; e.cnt = c; e.sat = s;
      q2.push_back(e);
   endtask

   // Present one beat and hold it until accepted. Afterwards, drive
   // junk payload/last with valid low; the DUT must ignore it.
   task automatic send(input int sel, input logic [31:0] p, input logic l);
      int n;
      n = 0;
      @(negedge clk);
      i_payload = p;
      i_last = l;
      if (sel == 0) v1 = 1'b1; else v2 = 1'b1;
      while (((sel == 0) ? !rdy1 : !rdy2) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         nvec++;
         nfail++;
         $display("FAIL send timeout: i_ready low for %0d cycles, required high", n);
      end
      @(posedge clk);
      #1;
      v1 = 1'b0;
      v2 = 1'b0;
      i_payload = 32'hDEAD_BEEF;
      i_last = 1'b1;
   endtask

   // Monitor: pops the scoreboard on every output handshake.
   always @(negedge clk) begin
      exp_t e;
      if (ov1 && o_ready) begin
         if (q1.size() == 0) begin
            nvec++; nfail++;
            $display("FAIL dut1 unexpected output: payload %h count %0d, required none", pay1, cnt1);
         end else begin
            e = q1.pop_front();
            chk("dut1 sum", 64'(pay1), e.pay);
            chk("dut1 count", 64'(cnt1), 64'(e.cnt));
`ifdef STREAM_ACCUMULATOR_SAT_EN
            chk("dut1 sat", 64'(sat1), 64'(e.sat));
`endif
         end
      end
      if (ov2 && o_ready) begin
         if (q2.size() == 0) begin
            nvec++; nfail++;
            $display("FAIL dut2 unexpected output: payload %h count %0d, required none", pay2, cnt2);
         end else begin
            e = q2.pop_front();
            chk("dut2 sum", 64'(pay2), e.pay);
            chk("dut2 count", 64'(cnt2), 64'(e.cnt));
`ifdef STREAM_ACCUMULATOR_SAT_EN
            chk("dut2 sat", 64'(sat2), 64'(e.sat));
`endif
         end
      end
   end

   initial begin
      // Reset held with i_valid asserted.
      #1 reset = 1'b0;
      v1 = 1'b1;
      i_payload = 32'd123;
      repeat (3) @(negedge clk);
      chk("reset i_ready", 64'(rdy1), 64'd0);
      chk("reset o_valid", 64'(ov1), 64'd0);
      chk("reset o_payload", 64'(pay1), 64'd0);
      chk("reset o_count", 64'(cnt1), 64'd0);
      v1 = 1'b0;
      #2 reset = 1'b1;
      @(negedge clk);
      chk("post-reset i_ready", 64'(rdy1), 64'd1);
      chk("post-reset o_valid", 64'(ov1), 64'd0);

      // Full frame with back-to-back beats.
      push1(100, 4, 0);
      send(0, 10, 0); send(0, 20, 0); send(0, 30, 0); send(0, 40, 0);
      chk("latency o_valid", 64'(ov1), 64'd1);
      chk("latency o_payload", 64'(pay1), 64'd100);
      chk("bubble i_ready", 64'(rdy1), 64'd0);
      @(posedge clk); #1;
      chk("after out i_ready", 64'(rdy1), 64'd1);
      chk("after out o_valid", 64'(ov1), 64'd0);

      // Early termination, then a one-beat frame starting from zero.
      push1(16, 2, 0);
      push1(5, 1, 0);
      send(0, 7, 0); send(0, 9, 1);
      send(0, 5, 1);
      @(posedge clk); #1;

      // Backpressure: the sum must stay put while o_ready is low.
      o_ready = 1'b0;
      push1(100, 4, 0);
      send(0, 10, 0); send(0, 20, 0); send(0, 30, 0); send(0, 40, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold o_valid", 64'(ov1), 64'd1);
         chk("hold o_payload", 64'(pay1), 64'd100);
         chk("hold i_ready", 64'(rdy1), 64'd0);
      end
      @(posedge clk); #1 o_ready = 1'b1;
      @(posedge clk); #1;
      chk("release o_valid", 64'(ov1), 64'd0);
      chk("release i_ready", 64'(rdy1), 64'd1);

      // Gaps, then an unaligned async reset mid-frame.
      send(0, 3, 0);
      repeat (2) @(posedge clk);
      send(0, 4, 0);
      #3 reset = 1'b0;
      #1;
      chk("async reset i_ready", 64'(rdy1), 64'd0);
      chk("async reset o_payload", 64'(pay1), 64'd0);
      chk("async reset o_count", 64'(cnt1), 64'd0);
      #3 reset = 1'b1;
      push1(4, 4, 0);
      send(0, 1, 0); send(0, 1, 0); send(0, 1, 0); send(0, 1, 0);

      // i_last coinciding with the LEN-th beat ends the frame once.
      push1(10, 4, 0);
      push1(6, 1, 0);
      send(0, 1, 0); send(0, 2, 0); send(0, 3, 0); send(0, 4, 1);
      send(0, 6, 1);

      // Full-scale products: no wrap at 40 bits.
      push1(64'h3_FFFF_FFFC, 4, 0);
      for (int i = 0; i < 4; i++) send(0, 32'hFFFF_FFFF, 0);

      // 33-bit accumulator: wrap, or saturate when enabled.
`ifdef STREAM_ACCUMULATOR_SAT_EN
      push2(64'h1_FFFF_FFFF, 4, 1);
`else
      push2(64'h1_FFFF_FFFC, 4, 0);
`endif
      for (int i = 0; i < 4; i++) send(1, 32'hFFFF_FFFF, 0);

      // Drain the scoreboards with a bounded wait.
      for (int i = 0; i < 20; i++) begin
         if (q1.size() == 0 && q2.size() == 0) break;
         @(posedge clk);
      end
      if (q1.size() != 0 || q2.size() != 0) begin
         nvec++; nfail++;
         $display("FAIL drain: %0d/%0d sums outstanding, required 0/0", q1.size(), q2.size());
      end
      @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
